// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl
// Programming front-end for the even clock divider. Accepts a ratio from the
// configuration host over valid/ready and validates it. It applies an accepted
// ratio only at the start of a low phase of the divided clock, so the
// switch-over is glitch-free. It then holds `locked` low for a settle window.
//
// Optional feature: define DIV_RATIO_TIMEOUT_EN to bound the wait for a
// falling edge of clk_div_fb. When the bound expires the ratio is applied
// anyway and cfg_err pulses once to flag the forced switch.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   cfg_valid   host request valid
//   cfg_ready   block can accept a request (registered)
//   cfg_div     requested ratio
//   cfg_err     one-cycle pulse: request rejected / forced switch (registered)
//   clk_div_fb  divided clock fed back from the divider (clk domain)
//   num_div     ratio driven to the divider (registered)
//   div_rst_n   active-low reset to the divider (registered)
//   locked      divided clock stable at num_div (registered)
module div_ratio_ctrl #(
  parameter int unsigned WIDTH_NUM_DIV = 4,
  parameter int unsigned DEFAULT_DIV   = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [WIDTH_NUM_DIV-1:0] cfg_div,
  output logic                     cfg_err,
  input  logic                     clk_div_fb,
  output logic [WIDTH_NUM_DIV-1:0] num_div,
  output logic                     div_rst_n,
  output logic                     locked
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]      SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH_NUM_DIV-1:0] DEF_DIV     = WIDTH_NUM_DIV'(DEFAULT_DIV);
  localparam logic [WIDTH_NUM_DIV-1:0] MIN_DIV     = WIDTH_NUM_DIV'(2);

`ifdef DIV_RATIO_TIMEOUT_EN
  localparam int unsigned TO_W = WIDTH_NUM_DIV + 1;
  // Last count value before the counter would reach all-ones.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_LOW,
    ST_APPLY,
    ST_SETTLE
  } state_e;

  state_e                     state_q, state_d;
  logic [WIDTH_NUM_DIV-1:0]   pending_q, pending_d;
  logic [WIDTH_NUM_DIV-1:0]   num_div_q, num_div_d;
  logic                       div_rst_n_q, div_rst_n_d;
  logic                       cfg_ready_q, cfg_ready_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       locked_q, locked_d;
  logic                       fb_d_q, fb_d_d;
  logic [SETTLE_W-1:0]        settle_cnt_q, settle_cnt_d;
  logic                       fb_fall;
`ifdef DIV_RATIO_TIMEOUT_EN
  logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
`endif

  // Falling edge of the divided clock marks the start of a low phase.
  assign fb_fall = fb_d_q & ~clk_div_fb;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    num_div_d    = num_div_q;
    div_rst_n_d  = div_rst_n_q;
    cfg_err_d    = 1'b0;
    locked_d     = locked_q;
    settle_cnt_d = settle_cnt_q;
    fb_d_d       = clk_div_fb;
`ifdef DIV_RATIO_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          pending_d = cfg_div;
          state_d   = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (pending_q[0] || (pending_q < MIN_DIV)) begin
          cfg_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (pending_q == num_div_q) begin
          state_d = ST_IDLE;
        end else begin
          locked_d = 1'b0;
          state_d  = ST_WAIT_LOW;
`ifdef DIV_RATIO_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end

      ST_WAIT_LOW: begin
        if (fb_fall) begin
          state_d = ST_APPLY;
        end
`ifdef DIV_RATIO_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          // Divider appears halted: force the switch and flag it.
          state_d   = ST_APPLY;
          cfg_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      ST_APPLY: begin
        // Output is already low here, so restarting the divider cannot glitch.
        num_div_d    = pending_q;
        div_rst_n_d  = 1'b0;
        settle_cnt_d = SETTLE_INIT;
        state_d      = ST_SETTLE;
      end

      ST_SETTLE: begin
        div_rst_n_d = 1'b1;
        if (settle_cnt_q == '0) begin
          locked_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Coming back from CHECK, ready is withheld one extra cycle.
    cfg_ready_d = (state_d == ST_IDLE) && (state_q != ST_CHECK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_SETTLE;
      pending_q    <= '0;
      num_div_q    <= DEF_DIV;
      div_rst_n_q  <= 1'b0;
      cfg_ready_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      locked_q     <= 1'b0;
      fb_d_q       <= 1'b0;
      settle_cnt_q <= SETTLE_INIT;
`ifdef DIV_RATIO_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      num_div_q    <= num_div_d;
      div_rst_n_q  <= div_rst_n_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
      locked_q     <= locked_d;
      fb_d_q       <= fb_d_d;
      settle_cnt_q <= settle_cnt_d;
`ifdef DIV_RATIO_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign num_div   = num_div_q;
  assign div_rst_n = div_rst_n_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Testbench for div_ratio_ctrl. A behavioural divider drives clk_div_fb from the
// expected ratio/reset. A transaction-level timeline model computes the expected
// outputs. A negedge process compares every output on every cycle after reset.
module tb_div_ratio_ctrl;

  localparam int unsigned W       = 4;
  localparam int unsigned SETTLE  = 4;
  localparam int          TO_WAIT = (1 << (W + 1)) - 1;

  logic         clk;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_div;
  logic         cfg_err;
  logic         clk_div_fb;
  logic [W-1:0] num_div;
  logic         div_rst_n;
  logic         locked;

  // Expected outputs
  logic         exp_ready;
  logic         exp_err;
  logic         exp_locked;
  logic         exp_drst;
  logic [W-1:0] exp_num;

  // Environment divider
  logic [W-1:0] dv_cnt;
  logic         dv_out;
  bit           fb_force0;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  div_ratio_ctrl #(
    .WIDTH_NUM_DIV(W),
    .DEFAULT_DIV  (2),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .clk_div_fb(clk_div_fb),
    .num_div   (num_div),
    .div_rst_n (div_rst_n),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Even divider: output toggles every num/2 cycles, held low in reset.
  always @(posedge clk) begin
    if (!exp_drst) begin
      dv_cnt <= '0;
      dv_out <= 1'b0;
    end else if (dv_cnt == W'((exp_num >> 1) - W'(1))) begin
      dv_cnt <= '0;
      dv_out <= ~dv_out;
    end else begin
      dv_cnt <= dv_cnt + W'(1);
    end
  end

  assign clk_div_fb = fb_force0 ? 1'b0 : dv_out;

  task automatic cmp(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp("cfg_ready", int'(cfg_ready), int'(exp_ready));
      cmp("cfg_err",   int'(cfg_err),   int'(exp_err));
      cmp("locked",    int'(locked),    int'(exp_locked));
      cmp("div_rst_n", int'(div_rst_n), int'(exp_drst));
      cmp("num_div",   int'(num_div),   int'(exp_num));
    end
  end

  // One clock: capture the feedback value the DUT samples at this edge.
  task automatic step(output logic fb);
    fb = clk_div_fb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int low_cycles, input bit early_valid, input logic [W-1:0] ev_div);
    logic f;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    for (int i = 0; i < low_cycles; i++) begin
      step(f);
      exp_num    = W'(2);
      exp_drst   = 1'b0;
      exp_ready  = 1'b0;
      exp_err    = 1'b0;
      exp_locked = 1'b0;
    end
    check_en = 1'b1;
    cmp("rst_num_div_lit", int'(num_div), 2);
    cmp("rst_locked_lit",  int'(locked),  0);
    rst_n     = 1'b1;
    cfg_valid = early_valid;
    cfg_div   = ev_div;
    step(f);
    exp_drst = 1'b1;
    cmp("rel_div_rst_n_lit", int'(div_rst_n), 1);
    step(f);
    step(f);
    cmp("rel_locked_early_lit", int'(locked), 0);
    step(f);
    exp_locked = 1'b1;
    exp_ready  = 1'b1;
    cmp("rel_locked_lit", int'(locked),    1);
    cmp("rel_ready_lit",  int'(cfg_ready), 1);
  endtask

  // One host request. abort_after>0 returns after that many WAIT_LOW edges.
  task automatic do_request(input logic [W-1:0] div, input bit hold_next,
                            input logic [W-1:0] next_div, input int abort_after);
    logic fb_prev;
    logic fb_cur;
    int   waited;
    waited    = 0;
    cfg_valid = 1'b1;
    cfg_div   = div;
    step(fb_cur);
    exp_ready = 1'b0;
    cfg_valid = hold_next;
    cfg_div   = hold_next ? next_div : W'($urandom_range(0, 15));
    step(fb_prev);
    if (div[0] || div < W'(2)) begin
      exp_err = 1'b1;
      step(fb_cur);
      exp_err   = 1'b0;
      exp_ready = 1'b1;
      return;
    end
    if (div == exp_num) begin
      step(fb_cur);
      exp_ready = 1'b1;
      return;
    end
    exp_locked = 1'b0;
    forever begin
      step(fb_cur);
      waited++;
      if (fb_prev && !fb_cur) break;
`ifdef DIV_RATIO_TIMEOUT_EN
      if (waited == TO_WAIT) begin
        exp_err = 1'b1;
        break;
      end
`endif
      if (waited == abort_after) return;
      if (waited > 2 * TO_WAIT) begin
        $display("FAIL wait_low_bound got=%0d exp<=%0d", waited, 2 * TO_WAIT);
        $fatal(1, "wait bound expired");
      end
      fb_prev = fb_cur;
    end
    step(fb_cur);
    exp_err  = 1'b0;
    exp_num  = div;
    exp_drst = 1'b0;
    step(fb_cur);
    exp_drst = 1'b1;
    repeat (SETTLE - 1) step(fb_cur);
    exp_locked = 1'b1;
    exp_ready  = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=%0t exp<400000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic         f;
    logic [W-1:0] nxt;
    bit           held;
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_div    = '0;
    fb_force0  = 1'b0;
    exp_num    = W'(2);
    exp_drst   = 1'b0;
    exp_ready  = 1'b0;
    exp_err    = 1'b0;
    exp_locked = 1'b0;
    held       = 1'b0;
    nxt        = '0;

    do_reset(2, 1'b0, '0);

    do_request(W'(6), 1'b0, '0, 0);
    cmp("req6_num_div_lit", int'(num_div), 6);
    cmp("req6_locked_lit",  int'(locked),  1);

    do_request(W'(5), 1'b0, '0, 0);
    do_request(W'(0), 1'b0, '0, 0);
    cmp("rej_num_div_lit", int'(num_div), 6);
    cmp("rej_locked_lit",  int'(locked),  1);

    do_request(W'(6), 1'b0, '0, 0);
    cmp("same_num_div_lit", int'(num_div), 6);

    // Reset while waiting for a low phase: the request for 10 is dropped.
    fb_force0 = 1'b1;
    do_request(W'(10), 1'b0, '0, 3);
    fb_force0 = 1'b0;
    do_reset(1, 1'b0, '0);

    // Divider feedback stuck low.
    fb_force0 = 1'b1;
`ifdef DIV_RATIO_TIMEOUT_EN
    do_request(W'(12), 1'b0, '0, 0);
    cmp("timeout_num_div_lit", int'(num_div), 12);
    fb_force0 = 1'b0;
`else
    do_request(W'(12), 1'b0, '0, 40);
    cmp("stuck_ready_lit",   int'(cfg_ready), 0);
    cmp("stuck_num_div_lit", int'(num_div),   2);
    fb_force0 = 1'b0;
    do_reset(1, 1'b0, '0);
`endif

    // Randomised traffic, including held requests and occasional resets.
    for (int it = 0; it < 60; it++) begin
      logic [W-1:0] d;
      logic [W-1:0] nd;
      bit           hn;
      if (held) begin
        d = nxt;
      end else begin
        cfg_valid = 1'b0;
        repeat ($urandom_range(0, 3)) step(f);
        if ($urandom_range(0, 3) == 0) d = exp_num;
        else d = W'($urandom_range(0, 15));
      end
      hn = ($urandom_range(0, 3) == 0);
      nd = W'($urandom_range(0, 15));
      do_request(d, hn, nd, 0);
      held = hn;
      nxt  = nd;
      if (!held && $urandom_range(0, 11) == 0) begin
        held = 1'($urandom_range(0, 1));
        nxt  = W'($urandom_range(0, 15));
        do_reset(int'($urandom_range(1, 2)), held, nxt);
      end
    end

    cfg_valid = 1'b0;
    step(f);
    step(f);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ratio_ctrl.md
# div_ratio_ctrl

Programming front-end for the even clock divider: accepts a new division ratio from the configuration host over a valid/ready handshake and validates it. It drives the divider's ratio input and local reset so a ratio change takes effect only at the start of a low phase of the divided clock, giving glitch-free switching. It sits directly upstream of the divider, in the same `clk` domain, and reports lock status to the clock consumers.

## Interface
- WIDTH_NUM_DIV, 4, width of the ratio bus; must match the divider.
- DEFAULT_DIV, 2, ratio loaded at reset; must be even and ≥2.
- SETTLE_CYCLES, 4, cycles `locked` stays low after a ratio is applied; ≥1.

- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- cfg_valid  in  1  host request valid.
- cfg_ready  out  1  block can accept a request.
- cfg_div  in  WIDTH_NUM_DIV  requested ratio.
- cfg_err  out  1  one-cycle pulse: request rejected.
- clk_div_fb  in  1  divided clock fed back from the divider (register output, `clk` domain).
- num_div  out  WIDTH_NUM_DIV  ratio to the divider (registered).
- div_rst_n  out  1  active-low reset to the divider (registered).
- locked  out  1  divided clock stable at `num_div`.

## Operation
- States:
  - IDLE: `cfg_ready`=1.
  - CHECK
  - WAIT_LOW
  - APPLY
  - SETTLE
- IDLE: a handshake (`cfg_valid`&&`cfg_ready`) captures `cfg_div` into `pending` and moves to CHECK.
- CHECK:
  - `pending` odd or <2: assert `cfg_err` for one cycle, go to IDLE, no other change.
  - `pending` == `num_div`: go to IDLE with no change; `locked` stays 1.
  - Otherwise: clear `locked` and go to WAIT_LOW.
- WAIT_LOW: `fb_d` holds `clk_div_fb` from the previous cycle. A falling edge is `fb_d`=1 && `clk_div_fb`=0; on it, go to APPLY.
- APPLY (one cycle): `num_div`<=`pending`, `div_rst_n`<=0. The divider counter and output restart from 0; the output is already low, so there is no glitch.
- SETTLE: `div_rst_n`<=1. A down-counter loaded with SETTLE_CYCLES−1 runs to 0, then the block sets `locked`<=1 and goes to IDLE.
- `fb_d` updates every cycle in all states.
- Host requests are ignored while `cfg_ready`=0; the host holds `cfg_valid`.

## Timing
- Reset values while `rst_n`=0:
  - `num_div`=DEFAULT_DIV
  - `div_rst_n`=0
  - `cfg_ready`=0
  - `cfg_err`=0
  - `locked`=0
  - `fb_d`=0
  - state=SETTLE with counter=SETTLE_CYCLES−1
- First edge with `rst_n`=1: `div_rst_n`=1.
- `locked` and `cfg_ready` rise SETTLE_CYCLES edges after reset release.
- Handshake at edge N:
  - CHECK at N+1.
  - Rejected: `cfg_err` high between edges N+1 and N+2, `cfg_ready` back at N+2.
- Accepted: `locked`=0 from N+1. APPLY follows the first falling edge of `clk_div_fb` seen at edge ≥N+2.
  - New `num_div` and `div_rst_n`=0 one cycle after that edge.
  - `locked`=1 SETTLE_CYCLES cycles later.
- Worst-case WAIT_LOW is one full old period, which is <2^WIDTH_NUM_DIV cycles.
- A synchronous reset in any state aborts the update and discards `pending`. The block returns to reset values next edge, including `num_div`=DEFAULT_DIV.
- `clk_div_fb` stuck (divider halted): WAIT_LOW holds indefinitely unless the timeout is compiled in.

## Configuration
- Macro `DIV_RATIO_TIMEOUT_EN`.
- Defined: WAIT_LOW has a timeout counter of WIDTH_NUM_DIV+1 bits, cleared on entry.
  - If it reaches 2^(WIDTH_NUM_DIV+1)−1 without a falling edge, go to APPLY anyway.
  - In the same cycle, `cfg_err` pulses for one cycle to flag a forced switch; the new ratio is still applied.
- Undefined: no timeout counter; WAIT_LOW waits for a falling edge forever.

## Test plan
- Reset release, DEFAULT_DIV=2 → `div_rst_n`=1 at edge 1; `locked`=`cfg_ready`=1 at edge 4 with SETTLE_CYCLES=4; `num_div`=2.
- Request 6 while the divider runs at 2 → `locked` drops next cycle; `num_div`=6 and `div_rst_n` low for exactly one cycle, right after a `clk_div_fb` 1→0; `locked`=1 four cycles later; no high pulse on the divided clock shorter than one period of `clk`.
- Request 5, then request 0 → one-cycle `cfg_err` each; `num_div` unchanged; `locked` stays 1.
- Request equal to current ratio (6) → no `div_rst_n` pulse; `cfg_ready` returns in 2 cycles.
- `rst_n` low during WAIT_LOW of a request for 10 → next edge `num_div`=2, `locked`=0; the request for 10 is never applied.
- With `DIV_RATIO_TIMEOUT_EN` and `clk_div_fb` tied 0 → APPLY after 31 WAIT_LOW cycles (W=4) with a `cfg_err` pulse. Without the macro → the block stays in WAIT_LOW and `cfg_ready`=0 throughout.
